led_display_sched: RTL

//  Display-mode scheduler for the LED bar path. Sits between the velocity

---
 rtl/led_display_sched_pkg.sv | 14 +
 rtl/led_display_sched_if.sv | 17 +
 rtl/led_display_sched_tick_gen.sv | 23 ++
 rtl/led_display_sched.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/led_display_sched_pkg.sv
// Shared types and constants for the LED bar display-mode scheduler.
package led_pkg;
    typedef enum logic [1:0] {SWEEP = 2'd0, RUN = 2'd1, DIM = 2'd2, FAULT = 2'd3} led_mode_t;

    localparam int          LED_W       = 16;
    localparam int          VEL_W       = 11;
    localparam logic [15:0] LED_ALL_ON  = 16'hFFFF;
    localparam logic [15:0] LED_ALL_OFF = 16'h0000;

    // Width needed to hold the values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/led_display_sched_if.sv
// Bus between the velocity/comparator side and the PWM stage.
interface led_display_sched_if;
    import led_pkg::*;

    logic [VEL_W-1:0] velocity;
    logic             vel_valid;
    logic [LED_W-1:0] led_bar;
    logic             fault;
    logic [LED_W-1:0] led_on;
    logic [7:0]       duty;
    led_mode_t        mode;

    modport master (output velocity, vel_valid, led_bar, fault,
                    input  led_on, duty, mode);
    modport slave  (input  velocity, vel_valid, led_bar, fault,
                    output led_on, duty, mode);
endinterface

// File: rtl/led_display_sched_tick_gen.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks.
module led_tick_gen
    import led_pkg::*;
#(
    parameter int TICK_DIV = 100_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int            CW   = cnt_w(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                r_cnt <= '0;
        else if (r_cnt == LAST) r_cnt <= '0;
        else                    r_cnt <= r_cnt + 1'b1;
    end

    assign tick = (r_cnt == LAST);
endmodule

// File: rtl/led_display_sched.sv
// Picks what drives the LED bar (sweep, live bar, dimmed bar, fault blink)
// and the matching PWM duty. All outputs are registered.
module led_display_sched
    import led_pkg::*;
#(
    parameter int         TICK_DIV    = 100_000,
    parameter int         SWEEP_TICKS = 30,
    parameter int         IDLE_TICKS  = 5000,
    parameter int         BLINK_TICKS = 250,
    parameter logic [7:0] DUTY_FULL   = 8'd255,
    parameter logic [7:0] DUTY_DIM    = 8'd32
) (
    input  logic               clk,
    input  logic               rst,
    led_display_sched_if.slave bus
);
    localparam int POS_W   = cnt_w(LED_W);
    localparam int STEP_W  = cnt_w(SWEEP_TICKS);
    localparam int IDLE_W  = cnt_w(IDLE_TICKS + 1);
    localparam int BLINK_W = cnt_w(BLINK_TICKS);

    localparam logic [POS_W-1:0]   POS_LAST   = POS_W'(LED_W - 1);
    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(SWEEP_TICKS - 1);
    localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(IDLE_TICKS - 1);
    localparam logic [IDLE_W-1:0]  IDLE_MAX   = IDLE_W'(IDLE_TICKS);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

    led_mode_t          r_mode, w_nxt;
    logic [POS_W-1:0]   r_pos, w_pos_n;
    logic [STEP_W-1:0]  r_step, w_step_n;
    logic [IDLE_W-1:0]  r_idle, w_idle_n;
    logic [BLINK_W-1:0] r_blink, w_blink_n;
    logic [LED_W-1:0]   r_led_on, w_led_n;
    logic [7:0]         r_duty, w_duty_n;
    logic [VEL_W-1:0]   r_vel_last;
    logic               w_tick, w_chg;

    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    assign w_chg = bus.vel_valid && (bus.velocity != r_vel_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_mode <= SWEEP;
        else     r_mode <= w_nxt;
    end

    always_comb begin
        w_nxt     = r_mode;
        w_pos_n   = r_pos;
        w_step_n  = r_step;
        w_idle_n  = r_idle;
        w_blink_n = r_blink;
        w_led_n   = r_led_on;
        // Fault overrides every other event, including a velocity change.
        if (bus.fault) begin
            w_nxt = FAULT;
            if (r_mode != FAULT) begin
                w_led_n   = LED_ALL_ON;
                w_blink_n = '0;
            end else if (w_tick) begin
                if (r_blink == BLINK_LAST) begin
                    w_blink_n = '0;
                    w_led_n   = ~r_led_on;
                end else begin
                    w_blink_n = r_blink + 1'b1;
                end
            end
        end else begin
            case (r_mode)
                SWEEP: begin
                    if (w_tick) begin
                        if (r_step == STEP_LAST) begin
                            w_step_n = '0;
                            if (r_pos == POS_LAST) begin
                                w_nxt   = RUN;
                                w_led_n = bus.led_bar;
                            end else begin
                                w_pos_n = r_pos + 1'b1;
                                w_led_n = LED_W'(1) << (r_pos + 1'b1);
                            end
                        end else begin
                            w_step_n = r_step + 1'b1;
                        end
                    end
                end
                RUN: begin
                    w_led_n = bus.led_bar;
                    // A change on the timeout tick keeps us in RUN.
                    if (w_chg) begin
                        w_idle_n = '0;
                    end else if (w_tick && r_idle != IDLE_MAX) begin
                        w_idle_n = r_idle + 1'b1;
                        if (r_idle == IDLE_LAST) w_nxt = DIM;
                    end
                end
                DIM: begin
                    w_led_n = bus.led_bar;
                    if (w_chg) begin
                        w_nxt    = RUN;
                        w_idle_n = '0;
                    end
                end
                FAULT: begin
                    w_nxt    = RUN;
                    w_idle_n = '0;
                    w_led_n  = bus.led_bar;
                end
                default: w_nxt = SWEEP;
            endcase
        end
        w_duty_n = (w_nxt == DIM) ? DUTY_DIM : DUTY_FULL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pos      <= '0;
            r_step     <= '0;
            r_idle     <= '0;
            r_blink    <= '0;
            r_led_on   <= 16'h0001;
            r_duty     <= DUTY_FULL;
            r_vel_last <= '0;
        end else begin
            r_pos    <= w_pos_n;
            r_step   <= w_step_n;
            r_idle   <= w_idle_n;
            r_blink  <= w_blink_n;
            r_led_on <= w_led_n;
            r_duty   <= w_duty_n;
            if (bus.vel_valid) r_vel_last <= bus.velocity;
        end
    end

    assign bus.led_on = r_led_on;
    assign bus.duty   = r_duty;
    assign bus.mode   = r_mode;
endmodule
